// File: rtl/packed_record_reader.sv
// Unpacks one {elem[N_ELEM-1:0], tail} record into one element beat per cycle, with the tail held on a side port.
// First beat appears 1 cycle after load; outputs hold while out_ready is low; a reload is taken on the last-beat transfer.
module packed_record_reader #(
    parameter  int N_ELEM    = 6,
    parameter  int ELEM_W    = 8,
    parameter  int TAIL_W    = 16,
    parameter  int MSB_FIRST = 0,
    localparam int REC_W     = N_ELEM*ELEM_W + TAIL_W,
    localparam int IDX_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REC_W-1:0]  in_rec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_elem,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [TAIL_W-1:0] out_tail
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    logic [REC_W-1:0]   r_rec;
    logic [IDX_W-1:0]   r_k;
    logic               r_out_valid;
    logic               r_out_last;
    logic [ELEM_W-1:0]  r_out_elem;
    logic [IDX_W-1:0]   r_out_idx;
    logic [TAIL_W-1:0]  r_out_tail;

    logic               w_load;
    logic               w_xfer;
    logic [REC_W-1:0]   w_src;
    logic [IDX_W-1:0]   w_k_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic [ELEM_W-1:0]  w_elem_next;
    logic               w_last_next;

    assign in_ready = (r_state == S_IDLE) | (r_out_valid & out_ready & r_out_last);
    assign w_load   = in_valid & in_ready;
    assign w_xfer   = r_out_valid & out_ready;

    // Next beat is precomputed so every output leaves a register; on a load it comes from in_rec directly.
    always_comb begin
        w_src    = w_load ? in_rec : r_rec;
        w_k_next = w_load ? '0 : r_k + 1'b1;
        if (MSB_FIRST != 0)
            w_idx_next = IDX_W'(N_ELEM - 1) - w_k_next;
        else
            w_idx_next = w_k_next;
        w_elem_next = w_src[TAIL_W + int'(w_idx_next)*ELEM_W +: ELEM_W];
        w_last_next = (w_k_next == IDX_W'(N_ELEM - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rec       <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_elem  <= '0;
            r_out_idx   <= '0;
            r_out_tail  <= '0;
        end else if (w_load) begin
            r_state     <= S_SEND;
            r_rec       <= in_rec;
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_next;
            r_out_elem  <= w_elem_next;
            r_out_idx   <= w_idx_next;
            r_out_tail  <= in_rec[TAIL_W-1:0];
        end else if (w_xfer) begin
            if (r_out_last) begin
                // Element/index/tail keep their final values while idle.
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_k         <= w_k_next;
                r_out_last  <= w_last_next;
                r_out_elem  <= w_elem_next;
                r_out_idx   <= w_idx_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_elem  = r_out_elem;
    assign out_idx   = r_out_idx;
    assign out_tail  = r_out_tail;

endmodule

// File: tb/tb_packed_record_reader.sv
// Bench for packed_record_reader: a 6-element LSB-first instance and an 8-element MSB-first instance.
module tb_packed_record_reader;

    typedef struct packed {
        logic [7:0]  elem;
        logic [2:0]  idx;
        logic        last;
        logic [15:0] tail;
    } beat_t;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [63:0] a_in_rec;
    logic [7:0]  a_out_elem;
    logic [2:0]  a_out_idx;
    logic [15:0] a_out_tail;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [79:0] b_in_rec;
    logic [7:0]  b_out_elem;
    logic [2:0]  b_out_idx;
    logic [15:0] b_out_tail;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t qa[$];
    beat_t qb[$];

    packed_record_reader #(.N_ELEM(6), .ELEM_W(8), .TAIL_W(16), .MSB_FIRST(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_rec(a_in_rec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_elem(a_out_elem),
        .out_idx(a_out_idx), .out_last(a_out_last), .out_tail(a_out_tail)
    );

    packed_record_reader #(.N_ELEM(8), .ELEM_W(8), .TAIL_W(16), .MSB_FIRST(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_rec(b_in_rec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_elem(b_out_elem),
        .out_idx(b_out_idx), .out_last(b_out_last), .out_tail(b_out_tail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a record becomes the list of beats it must produce, in emission order.
    task automatic push_rec(input int d, input logic [79:0] rec);
        int    n;
        int    i;
        beat_t bt;
        n = (d == 0) ? 6 : 8;
        for (int k = 0; k < n; k++) begin
            i       = (d == 0) ? k : n - 1 - k;
            bt.elem = 8'((rec >> (16 + i*8)) & 80'hFF);
            bt.idx  = 3'(i);
            bt.last = (k == n - 1);
            bt.tail = rec[15:0];
            if (d == 0) qa.push_back(bt); else qb.push_back(bt);
        end
    endtask

    // One cycle on DUT d: drive, check against the reference, advance the reference at the edge.
    task automatic step(input int d, input bit v, input logic [79:0] rec, input bit rdy);
        int    sz;
        bit    mrdy;
        beat_t f;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        if (d == 0) begin
            a_in_valid = v; a_in_rec = rec[63:0]; a_out_ready = rdy; sz = qa.size();
            if (sz != 0) f = qa[0];
        end else begin
            b_in_valid = v; b_in_rec = rec; b_out_ready = rdy; sz = qb.size();
            if (sz != 0) f = qb[0];
        end
        mrdy = (sz == 0) || (sz == 1 && rdy);
        #1;
        if (d == 0) begin
            chk("a_in_ready", 80'(a_in_ready), 80'(mrdy));
            chk("a_out_valid", 80'(a_out_valid), 80'(sz != 0));
            if (sz != 0) begin
                chk("a_out_elem", 80'(a_out_elem), 80'(f.elem));
                chk("a_out_idx", 80'(a_out_idx), 80'(f.idx));
                chk("a_out_last", 80'(a_out_last), 80'(f.last));
                chk("a_out_tail", 80'(a_out_tail), 80'(f.tail));
            end else begin
                chk("a_out_last_idle", 80'(a_out_last), 80'(0));
            end
        end else begin
            chk("b_in_ready", 80'(b_in_ready), 80'(mrdy));
            chk("b_out_valid", 80'(b_out_valid), 80'(sz != 0));
            if (sz != 0) begin
                chk("b_out_elem", 80'(b_out_elem), 80'(f.elem));
                chk("b_out_idx", 80'(b_out_idx), 80'(f.idx));
                chk("b_out_last", 80'(b_out_last), 80'(f.last));
                chk("b_out_tail", 80'(b_out_tail), 80'(f.tail));
            end else begin
                chk("b_out_last_idle", 80'(b_out_last), 80'(0));
            end
        end
        @(posedge clk);
        if (sz != 0 && rdy) begin
            if (d == 0) qa.delete(0); else qb.delete(0);
        end
        if (v && mrdy) push_rec(d, rec);
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_valid"}, 80'(a_out_valid), 80'(0));
        chk({tag, "_last"}, 80'(a_out_last), 80'(0));
        chk({tag, "_idx"}, 80'(a_out_idx), 80'(0));
        chk({tag, "_elem"}, 80'(a_out_elem), 80'(0));
        chk({tag, "_tail"}, 80'(a_out_tail), 80'(0));
        chk({tag, "_in_ready"}, 80'(a_in_ready), 80'(1));
    endtask

    task automatic pulse_rst();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_a("midrst");
        #1 rst = 1'b0;
        qa.delete();
        qb.delete();
        @(negedge clk);
    endtask

    localparam logic [79:0] REC1 = 80'h0000_4200_0012_3400_FFFC;
    localparam logic [79:0] REC2 = 80'hFC00_4200_0012_3400_FFFC;
    localparam logic [79:0] REC4 = 80'h0000_0102_0304_0506_AAAA;
    localparam logic [79:0] REC6 = 80'h0000_DEAD_BEEF_CAFE_5555;

    initial begin
        logic [95:0] r;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_rec = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_rec = '0; b_out_ready = 1'b0;
        #3;
        check_reset_a("reset_a");
        chk("reset_b_valid", 80'(b_out_valid), 80'(0));
        chk("reset_b_tail", 80'(b_out_tail), 80'(0));
        chk("reset_b_in_ready", 80'(b_in_ready), 80'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain stream, LSB-first
        step(0, 1'b1, REC1, 1'b1);
        for (int i = 0; i < 7; i++) step(0, 1'b0, '0, 1'b1);

        // MSB-first, eight elements
        step(1, 1'b1, REC2, 1'b1);
        for (int i = 0; i < 9; i++) step(1, 1'b0, '0, 1'b1);

        // Stalls with out_ready pattern 1,0,0
        step(0, 1'b1, REC1, 1'b1);
        for (int i = 0; i < 20; i++) step(0, 1'b0, '0, (i % 3) == 0);

        // Back-to-back reload on the last beat
        step(0, 1'b1, REC1, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 1'b0, '0, 1'b1);
        step(0, 1'b1, REC4, 1'b1);
        for (int i = 0; i < 7; i++) step(0, 1'b0, '0, 1'b1);

        // in_valid held through SEND with a different record
        step(0, 1'b1, REC1, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 1'b1, REC6, (i % 2) == 0);
        for (int i = 0; i < 8; i++) step(0, 1'b0, '0, 1'b1);

        // Async reset during beat idx2, then reload
        step(0, 1'b1, REC1, 1'b1);
        step(0, 1'b0, '0, 1'b1);
        step(0, 1'b0, '0, 1'b1);
        pulse_rst();
        step(0, 1'b1, REC1, 1'b1);
        for (int i = 0; i < 7; i++) step(0, 1'b0, '0, 1'b1);

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step(0, ($urandom_range(0, 1) == 1), r[79:0], ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 10; i++) step(0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step(1, ($urandom_range(0, 1) == 1), r[79:0], ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
